arcade_output_device: RTL and testbench



---
 rtl/arcade_output_device.sv | 216 +++++++++++++++++++++
 tb/tb_arcade_output_device.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/arcade_output_device.sv
// Two-byte command parser driving NUM_OUTPUTS lamp/solenoid pins from the CDC OUT stream.
// Optional pulse opcode 'P' is compiled in when ARCADE_OUT_PULSE_EN is defined.
module arcade_output_device #(
  parameter int NUM_OUTPUTS    = 8,
  parameter int TIMEOUT_FRAMES = 8,
  parameter int PULSE_FRAMES   = 16
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic [7:0]             out_data_i,
  input  logic                   out_valid_i,
  output logic                   out_ready_o,
  output logic [7:0]             in_data_o,
  output logic                   in_valid_o,
  input  logic                   in_ready_i,
  input  logic [10:0]            frame_i,
  input  logic                   usb_configured_i,
  output logic [NUM_OUTPUTS-1:0] outputs_o
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_GET_ARG = 2'd1;
  localparam logic [1:0] ST_RESP    = 2'd2;

  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] OP_SET   = 8'h53;
  localparam logic [7:0] OP_CLEAR = 8'h43;
  localparam logic [7:0] OP_READ  = 8'h52;
  localparam logic [7:0] RSP_ACK  = 8'h06;
  localparam logic [7:0] RSP_NAK  = 8'h15;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT_FRAMES);

`ifdef ARCADE_OUT_PULSE_EN
  localparam logic [7:0] OP_PULSE = 8'h50;
  localparam logic [7:0] PULSE_C  = 8'(PULSE_FRAMES);
`else
  localparam int PULSE_FRAMES_UNUSED = PULSE_FRAMES;
`endif

  function automatic logic opcode_valid(input logic [7:0] op);
    case (op)
      OP_WRITE, OP_SET, OP_CLEAR, OP_READ: opcode_valid = 1'b1;
`ifdef ARCADE_OUT_PULSE_EN
      OP_PULSE: opcode_valid = 1'b1;
`endif
      default: opcode_valid = 1'b0;
    endcase
  endfunction

  logic [1:0]             state_r, state_n;
  logic [7:0]             opcode_r, opcode_n;
  logic [7:0]             timeout_r, timeout_n;
  logic [NUM_OUTPUTS-1:0] outputs_r, outputs_n;
  logic [7:0]             in_data_r, in_data_n;
  logic                   in_valid_r, in_valid_n;
  logic                   out_ready_r, out_ready_n;
  logic                   frame_r;
  logic                   tick_s;
  logic                   xfer_s;
  logic [NUM_OUTPUTS-1:0] arg_s;
  logic [7:0]             rd_byte_s;
  logic                   frame_unused_s;
`ifdef ARCADE_OUT_PULSE_EN
  logic [NUM_OUTPUTS-1:0] pulse_mask_r, pulse_mask_n;
  logic [7:0]             pulse_cnt_r, pulse_cnt_n;
`endif

  // Only the frame LSB is needed to detect a new 1 ms frame.
  assign frame_unused_s = ^frame_i[10:1];
  assign tick_s         = frame_i[0] ^ frame_r;
  assign xfer_s         = out_valid_i & out_ready_r;
  assign arg_s          = out_data_i[NUM_OUTPUTS-1:0];

  // Zero-extend the pin state into a readback byte.
  always_comb begin
    rd_byte_s                  = 8'h00;
    rd_byte_s[NUM_OUTPUTS-1:0] = outputs_r;
  end

  // Command parser next-state and datapath.
  always_comb begin
    state_n    = state_r;
    opcode_n   = opcode_r;
    timeout_n  = timeout_r;
    outputs_n  = outputs_r;
    in_data_n  = in_data_r;
    in_valid_n = in_valid_r;
`ifdef ARCADE_OUT_PULSE_EN
    pulse_mask_n = pulse_mask_r;
    pulse_cnt_n  = pulse_cnt_r;
`endif
    if (!usb_configured_i) begin
      // Deconfiguration aborts everything; the OUT side keeps draining stale bytes.
      state_n    = ST_IDLE;
      timeout_n  = 8'd0;
      outputs_n  = {NUM_OUTPUTS{1'b0}};
      in_valid_n = 1'b0;
`ifdef ARCADE_OUT_PULSE_EN
      pulse_mask_n = {NUM_OUTPUTS{1'b0}};
      pulse_cnt_n  = 8'd0;
`endif
    end else begin
`ifdef ARCADE_OUT_PULSE_EN
      if (tick_s && (pulse_mask_r != {NUM_OUTPUTS{1'b0}})) begin
        if (pulse_cnt_r <= 8'd1) begin
          pulse_cnt_n  = 8'd0;
          pulse_mask_n = {NUM_OUTPUTS{1'b0}};
          outputs_n    = outputs_r & ~pulse_mask_r;
        end else begin
          pulse_cnt_n = pulse_cnt_r - 8'd1;
        end
      end else begin
        pulse_cnt_n = pulse_cnt_r;
      end
`endif
      case (state_r)
        ST_IDLE: begin
          if (xfer_s) begin
            opcode_n = out_data_i;
            if (opcode_valid(out_data_i)) begin
              state_n   = ST_GET_ARG;
              timeout_n = 8'd0;
            end else begin
              state_n    = ST_RESP;
              in_data_n  = RSP_NAK;
              in_valid_n = 1'b1;
            end
          end else begin
            state_n = ST_IDLE;
          end
        end
        ST_GET_ARG: begin
          if (xfer_s) begin
            state_n    = ST_RESP;
            in_valid_n = 1'b1;
            in_data_n  = RSP_ACK;
            case (opcode_r)
              OP_WRITE: outputs_n = arg_s;
              OP_SET:   outputs_n = outputs_n | arg_s;
              OP_CLEAR: outputs_n = outputs_n & ~arg_s;
              OP_READ:  in_data_n = rd_byte_s;
`ifdef ARCADE_OUT_PULSE_EN
              // A fresh pulse restarts the timer, so a same-cycle expiry must not drop old bits.
              OP_PULSE: begin
                outputs_n    = outputs_r | arg_s;
                pulse_mask_n = pulse_mask_r | arg_s;
                pulse_cnt_n  = PULSE_C;
              end
`endif
              default:  in_data_n = RSP_NAK;
            endcase
          end else if (timeout_r == TIMEOUT_C) begin
            state_n    = ST_RESP;
            in_valid_n = 1'b1;
            in_data_n  = RSP_NAK;
          end else if (tick_s) begin
            timeout_n = timeout_r + 8'd1;
          end else begin
            timeout_n = timeout_r;
          end
        end
        ST_RESP: begin
          if (in_ready_i) begin
            state_n    = ST_IDLE;
            in_valid_n = 1'b0;
          end else begin
            in_valid_n = 1'b1;
          end
        end
        default: begin
          state_n    = ST_IDLE;
          in_valid_n = 1'b0;
        end
      endcase
    end
    out_ready_n = (state_n != ST_RESP);
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_r     <= ST_IDLE;
      opcode_r    <= 8'h00;
      timeout_r   <= 8'd0;
      outputs_r   <= {NUM_OUTPUTS{1'b0}};
      in_data_r   <= 8'h00;
      in_valid_r  <= 1'b0;
      out_ready_r <= 1'b0;
      frame_r     <= 1'b0;
`ifdef ARCADE_OUT_PULSE_EN
      pulse_mask_r <= {NUM_OUTPUTS{1'b0}};
      pulse_cnt_r  <= 8'd0;
`endif
    end else begin
      state_r     <= state_n;
      opcode_r    <= opcode_n;
      timeout_r   <= timeout_n;
      outputs_r   <= outputs_n;
      in_data_r   <= in_data_n;
      in_valid_r  <= in_valid_n;
      out_ready_r <= out_ready_n;
      frame_r     <= frame_i[0];
`ifdef ARCADE_OUT_PULSE_EN
      pulse_mask_r <= pulse_mask_n;
      pulse_cnt_r  <= pulse_cnt_n;
`endif
    end
  end

  assign out_ready_o = out_ready_r;
  assign in_data_o   = in_data_r;
  assign in_valid_o  = in_valid_r;
  assign outputs_o   = outputs_r;

endmodule

// File: tb/tb_arcade_output_device.sv
// Scoreboard bench for arcade_output_device: responses are queued as commands are sent
// and compared when the IN handshake fires; pin state is compared against a small model.
module tb_arcade_output_device;

  localparam logic [7:0] ACK = 8'h06;
  localparam logic [7:0] NAK = 8'h15;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic [7:0]  out_data_i;
  logic        out_valid_i;
  logic        out_ready_o;
  logic [7:0]  in_data_o;
  logic        in_valid_o;
  logic        in_ready_i;
  logic [10:0] frame_i;
  logic        usb_configured_i;
  logic [7:0]  outputs_o;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] sb[$];
  logic [7:0] exp_out;

  arcade_output_device #(.NUM_OUTPUTS(8), .TIMEOUT_FRAMES(8), .PULSE_FRAMES(16)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .out_data_i(out_data_i), .out_valid_i(out_valid_i), .out_ready_o(out_ready_o),
    .in_data_o(in_data_o), .in_valid_o(in_valid_o), .in_ready_i(in_ready_i),
    .frame_i(frame_i), .usb_configured_i(usb_configured_i), .outputs_o(outputs_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Response monitor: a handshake seen at the falling edge completes on the next rising edge.
  always @(negedge clk_i) begin
    if (rstn_i && in_valid_o && in_ready_i) begin
      check_value("resp_expected", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) check_value("resp_byte", {24'd0, in_data_o}, {24'd0, sb.pop_front()});
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int k;
    k = 0;
    @(negedge clk_i);
    out_data_i  = b;
    out_valid_i = 1'b1;
    while (!out_ready_o && k < 500) begin
      @(negedge clk_i);
      k++;
    end
    if (k >= 500) check_value("accept_timeout", k, 0);
    @(negedge clk_i);
    out_valid_i = 1'b0;
  endtask

  task automatic send_cmd(input logic [7:0] op, input logic [7:0] arg);
    logic has_arg;
    has_arg = 1'b1;
    case (op)
      8'h57: begin exp_out = arg;            sb.push_back(ACK); end
      8'h53: begin exp_out = exp_out | arg;  sb.push_back(ACK); end
      8'h43: begin exp_out = exp_out & ~arg; sb.push_back(ACK); end
      8'h52: sb.push_back(exp_out);
`ifdef ARCADE_OUT_PULSE_EN
      8'h50: begin exp_out = exp_out | arg;  sb.push_back(ACK); end
`endif
      default: begin sb.push_back(NAK); has_arg = 1'b0; end
    endcase
    send_byte(op);
    if (has_arg) send_byte(arg);
    check_value("outputs_after_cmd", {24'd0, outputs_o}, {24'd0, exp_out});
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 300) begin
      @(negedge clk_i);
      k++;
    end
    check_value("resp_drain", sb.size(), 0);
  endtask

  task automatic frame_tick();
    @(posedge clk_i);
    #1 frame_i = frame_i + 11'd1;
    repeat (2) @(posedge clk_i);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int st;
    rstn_i = 1'b0; usb_configured_i = 1'b0; out_valid_i = 1'b0; out_data_i = 8'h00;
    in_ready_i = 1'b1; frame_i = 11'd0; exp_out = 8'h00;
    repeat (3) @(negedge clk_i);
    check_value("rst_outputs", {24'd0, outputs_o}, 32'd0);
    check_value("rst_in_valid", {31'd0, in_valid_o}, 32'd0);
    check_value("rst_out_ready", {31'd0, out_ready_o}, 32'd0);
    check_value("rst_in_data", {24'd0, in_data_o}, 32'd0);
    rstn_i = 1'b1;
    @(negedge clk_i);
    usb_configured_i = 1'b1;
    repeat (2) @(negedge clk_i);
    check_value("idle_out_ready", {31'd0, out_ready_o}, 32'd1);

    // Write, readback, set and clear.
    send_cmd(8'h57, 8'hA5);
    send_cmd(8'h52, 8'h00);
    send_cmd(8'h57, 8'hF0);
    send_cmd(8'h53, 8'h0F);
    send_cmd(8'h43, 8'h81);
    wait_drain();

    // Unknown opcode is NAKed at once; the next byte is a fresh opcode.
    send_cmd(8'h99, 8'h00);
    send_cmd(8'h52, 8'h00);
    wait_drain();

    // Argument withheld: no response after 7 frames, NAK after the 8th.
    sb.push_back(NAK);
    send_byte(8'h57);
    repeat (7) frame_tick();
    repeat (3) @(negedge clk_i);
    check_value("to_early_valid", {31'd0, in_valid_o}, 32'd0);
    check_value("to_early_ready", {31'd0, out_ready_o}, 32'd1);
    frame_tick();
    wait_drain();
    check_value("to_outputs_kept", {24'd0, outputs_o}, {24'd0, exp_out});

    // Argument lands on the exact timeout cycle: the transfer wins.
    sb.push_back(ACK);
    send_byte(8'h57);
    repeat (7) frame_tick();
    @(posedge clk_i);
    #1 frame_i = frame_i + 11'd1;
    @(posedge clk_i);
    @(negedge clk_i);
    out_data_i = 8'h3C; out_valid_i = 1'b1;
    check_value("to_edge_ready", {31'd0, out_ready_o}, 32'd1);
    @(negedge clk_i);
    out_valid_i = 1'b0;
    exp_out = 8'h3C;
    check_value("to_edge_outputs", {24'd0, outputs_o}, {24'd0, exp_out});
    wait_drain();

    // Response held by back-pressure, then deconfiguration aborts it.
    @(posedge clk_i);
    #1 in_ready_i = 1'b0;
    send_cmd(8'h57, 8'h5A);
    st = 0;
    repeat (100) begin
      @(negedge clk_i);
      if (in_valid_o && in_data_o == ACK && !out_ready_o) st++;
    end
    check_value("resp_hold", st, 100);
    usb_configured_i = 1'b0;
    sb.delete();
    exp_out = 8'h00;
    @(negedge clk_i);
    check_value("deconf_outputs", {24'd0, outputs_o}, 32'd0);
    check_value("deconf_in_valid", {31'd0, in_valid_o}, 32'd0);
    check_value("deconf_out_ready", {31'd0, out_ready_o}, 32'd1);
    send_byte(8'h57);
    send_byte(8'hFF);
    check_value("deconf_drain_outputs", {24'd0, outputs_o}, 32'd0);
    @(posedge clk_i);
    #1 in_ready_i = 1'b1;
    @(negedge clk_i);
    usb_configured_i = 1'b1;
    repeat (3) @(negedge clk_i);
    check_value("reconf_no_resp", {31'd0, in_valid_o}, 32'd0);
    send_cmd(8'h52, 8'h00);
    wait_drain();

`ifdef ARCADE_OUT_PULSE_EN
    send_cmd(8'h50, 8'h03);
    repeat (15) frame_tick();
    check_value("pulse_held", {24'd0, outputs_o}, 32'h03);
    frame_tick();
    repeat (2) @(negedge clk_i);
    exp_out = exp_out & ~8'h03;
    check_value("pulse_expired", {24'd0, outputs_o}, {24'd0, exp_out});
`else
    send_cmd(8'h50, 8'h03);
`endif
    wait_drain();

    // Asynchronous reset in the middle of a pending response.
    @(posedge clk_i);
    #1 in_ready_i = 1'b0;
    send_cmd(8'h57, 8'hC3);
    repeat (3) @(negedge clk_i);
    rstn_i = 1'b0;
    #1;
    check_value("mid_rst_outputs", {24'd0, outputs_o}, 32'd0);
    check_value("mid_rst_in_valid", {31'd0, in_valid_o}, 32'd0);
    check_value("mid_rst_out_ready", {31'd0, out_ready_o}, 32'd0);
    check_value("mid_rst_in_data", {24'd0, in_data_o}, 32'd0);
    sb.delete();
    repeat (2) @(negedge clk_i);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
